mem_stage: RTL and testbench

Memory-access pipeline stage, directly downstream of the execute stage; consumes the EX/MEM register outputs.
- Issues loads and stores to a data memory over a valid/ready handshake and stalls the pipeline on wait states.
- Resolves branch, jump and return redirects.
- Publishes the MEM-stage forwarding value.
- Contains the MEM/WB pipeline register feeding write-back.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/mem_stage_lsu_align.sv | 60 ++++++
 rtl/mem_stage.sv | 174 +++++++++++++++++
 tb/tb_mem_stage.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared types and encodings for the memory-access pipeline stage.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int XLEN = 32;

  // Write-back source select
  localparam logic [1:0] WS_ALU  = 2'b00;
  localparam logic [1:0] WS_LOAD = 2'b01;
  localparam logic [1:0] WS_PC4  = 2'b10;
  localparam logic [1:0] WS_IMM  = 2'b11;

  // Load/store access size and sign (funct3)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Data-memory access state
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_stage_lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Purpose  : Byte-lane alignment for the data-memory port: store byte enables
//            and lane replication, misalignment detection, load extraction
//            and sign/zero extension. Purely combinational.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            misalign_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selected by the low address bits
  assign w_byte = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // Store lane formation and alignment check, keyed on access size
  always_comb begin
    be_o       = 4'b1111;
    wdata_o    = wdata_i;
    misalign_o = 1'b0;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o       = 4'b0011 << addr_lo_i;
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = addr_lo_i[0];
      end
      default: misalign_o = |addr_lo_i;
    endcase
  end

  // Load extraction with sign or zero extension
  always_comb begin
    case (funct3_i)
      F3_B:    rdata_o = {{24{w_byte[7]}}, w_byte};
      F3_H:    rdata_o = {{16{w_half[15]}}, w_half};
      F3_BU:   rdata_o = {24'd0, w_byte};
      F3_HU:   rdata_o = {16'd0, w_half};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access pipeline stage. Issues loads/stores over a
//            valid/ready data-memory port, stalls on wait states with a
//            timeout, resolves control-flow redirects and holds the MEM/WB
//            pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int MEM_TIMEOUT = 16,
  parameter int XLEN        = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            EQ_i,
  input  logic [XLEN-1:0] ALUout_i,
  input  logic            RegWrite_i,
  input  logic [1:0]      WriteSrc_i,
  input  logic            Branch_i,
  input  logic            Jump_i,
  input  logic            Ret_i,
  input  logic            MemWrite_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] ImmOp_i,
  input  logic [XLEN-1:0] pcPlus4_i,
  input  logic [XLEN-1:0] pcPlusImm_i,
  input  logic [XLEN-1:0] regOp2_i,
  input  logic [4:0]      rd_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [3:0]      dmem_be_o,
  input  logic            dmem_ready_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            stall_o,
  output logic            PCsrc_o,
  output logic [XLEN-1:0] PCTarget_o,
  output logic [XLEN-1:0] ALUResultM_o,
  output logic            RegWriteM_o,
  output logic [4:0]      rdM_o,
  output logic            misalign_o,
  output logic            err_o,
  output logic            RegWrite_o,
  output logic [1:0]      WriteSrc_o,
  output logic [XLEN-1:0] ALUout_o,
  output logic [XLEN-1:0] ReadData_o,
  output logic [XLEN-1:0] pcPlus4_o,
  output logic [XLEN-1:0] ImmOp_o,
  output logic [4:0]      rd_o
);

  import mem_pkg::*;

  localparam int              CNT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;

  logic              regwrite_q, regwrite_d;
  logic [1:0]        writesrc_q, writesrc_d;
  logic [XLEN-1:0]   aluout_q, readdata_q, readdata_d, pcplus4_q, immop_q;
  logic [4:0]        rd_q;

  logic              w_access, w_size_misal, w_issue, w_in_wait;
  logic              w_complete, w_abandon;
  logic [XLEN-1:0]   w_load_data;

  lsu_align u_align (
    .funct3_i   (funct3_i),
    .addr_lo_i  (ALUout_i[1:0]),
    .wdata_i    (regOp2_i),
    .rdata_i    (dmem_rdata_i),
    .be_o       (dmem_be_o),
    .wdata_o    (dmem_wdata_o),
    .rdata_o    (w_load_data),
    .misalign_o (w_size_misal)
  );

  assign w_in_wait  = (state_q == WAIT);
  assign w_access   = (WriteSrc_i == WS_LOAD) | MemWrite_i;
  assign w_issue    = w_access & ~w_size_misal;

  // Reset gates the request so an in-flight WAIT drops it at once
  assign dmem_req_o  = rst_ni & (w_in_wait | w_issue);
  assign dmem_we_o   = dmem_req_o & MemWrite_i;
  assign dmem_addr_o = {ALUout_i[XLEN-1:2], 2'b00};
  assign misalign_o  = ~w_in_wait & w_access & w_size_misal;

  assign w_complete = dmem_req_o & dmem_ready_i;
  assign w_abandon  = rst_ni & w_in_wait & ~dmem_ready_i & (cnt_q == CNT_LAST);
  assign stall_o    = dmem_req_o & ~dmem_ready_i & ~w_abandon;

  // Control-flow redirect; loads/stores never carry control flow
  assign PCsrc_o    = Jump_i | Ret_i | (Branch_i & (EQ_i ^ funct3_i[0]));
  assign PCTarget_o = Ret_i ? {ALUout_i[XLEN-1:1], 1'b0} : pcPlusImm_i;

  assign ALUResultM_o = ALUout_i;
  assign RegWriteM_o  = RegWrite_i;
  assign rdM_o        = rd_i;
  assign err_o        = err_q;

  // Access FSM with wait counter and sticky error flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (misalign_o | w_abandon) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (w_issue & ~dmem_ready_i) begin
            state_q <= WAIT;
            cnt_q   <= CNT_W'(1);
          end
        end
        WAIT: begin
          if (dmem_ready_i | w_abandon) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // MEM/WB next value: bubble on stall, write suppressed on faults
  always_comb begin
    regwrite_d = RegWrite_i & ~stall_o & ~misalign_o & ~w_abandon;
    writesrc_d = stall_o ? WS_ALU : WriteSrc_i;
    readdata_d = w_complete ? w_load_data : '0;
  end

  // MEM/WB pipeline register, captured every cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regwrite_q <= 1'b0;
      writesrc_q <= '0;
      aluout_q   <= '0;
      readdata_q <= '0;
      pcplus4_q  <= '0;
      immop_q    <= '0;
      rd_q       <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      writesrc_q <= writesrc_d;
      aluout_q   <= ALUout_i;
      readdata_q <= readdata_d;
      pcplus4_q  <= pcPlus4_i;
      immop_q    <= ImmOp_i;
      rd_q       <= rd_i;
    end
  end

  assign RegWrite_o = regwrite_q;
  assign WriteSrc_o = writesrc_q;
  assign ALUout_o   = aluout_q;
  assign ReadData_o = readdata_q;
  assign pcPlus4_o  = pcplus4_q;
  assign ImmOp_o    = immop_q;
  assign rd_o       = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage: a per-cycle reference model
//            plus directed vectors with hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  localparam int MEM_TIMEOUT = 16;

  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        EQ_i = 0, RegWrite_i = 0, Branch_i = 0, Jump_i = 0, Ret_i = 0, MemWrite_i = 0;
  logic [1:0]  WriteSrc_i = 0;
  logic [2:0]  funct3_i = 0;
  logic [31:0] ALUout_i = 0, ImmOp_i = 0, pcPlus4_i = 0, pcPlusImm_i = 0, regOp2_i = 0;
  logic [4:0]  rd_i = 0;
  logic        dmem_ready_i = 0;
  logic [31:0] dmem_rdata_i = 0;
  logic        dmem_req_o, dmem_we_o, stall_o, PCsrc_o, RegWriteM_o, misalign_o, err_o, RegWrite_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, PCTarget_o, ALUResultM_o, ALUout_o, ReadData_o, pcPlus4_o, ImmOp_o;
  logic [3:0]  dmem_be_o;
  logic [4:0]  rdM_o, rd_o;
  logic [1:0]  WriteSrc_o;

  mem_stage #(.MEM_TIMEOUT(MEM_TIMEOUT), .XLEN(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .EQ_i(EQ_i), .ALUout_i(ALUout_i), .RegWrite_i(RegWrite_i),
    .WriteSrc_i(WriteSrc_i), .Branch_i(Branch_i), .Jump_i(Jump_i), .Ret_i(Ret_i),
    .MemWrite_i(MemWrite_i), .funct3_i(funct3_i), .ImmOp_i(ImmOp_i), .pcPlus4_i(pcPlus4_i),
    .pcPlusImm_i(pcPlusImm_i), .regOp2_i(regOp2_i), .rd_i(rd_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_ready_i(dmem_ready_i),
    .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o), .PCsrc_o(PCsrc_o), .PCTarget_o(PCTarget_o),
    .ALUResultM_o(ALUResultM_o), .RegWriteM_o(RegWriteM_o), .rdM_o(rdM_o),
    .misalign_o(misalign_o), .err_o(err_o), .RegWrite_o(RegWrite_o), .WriteSrc_o(WriteSrc_o),
    .ALUout_o(ALUout_o), .ReadData_o(ReadData_o), .pcPlus4_o(pcPlus4_o), .ImmOp_o(ImmOp_o),
    .rd_o(rd_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model helpers ----------------
  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
    int n = nbytes(f3);
    int off = int'(addr[1:0]);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*((off + i) % 4) +: 8];
    if (!f3[2] && n < 4 && v[8*n-1])
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    int n = nbytes(f3);
    int off = int'(addr[1:0]);
    logic [3:0] b = '0;
    for (int i = 0; i < 4; i++) b[i] = (i >= off) && (i < off + n);
    return b;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    int n = nbytes(f3);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
    return w;
  endfunction

  // ---------------- per-cycle compare process ----------------
  initial begin : cmp
    int          m_pend;    // cycles the current access has already waited
    bit          m_err;
    logic        e_rw;
    logic [1:0]  e_ws;
    logic [31:0] e_alu, e_rdat, e_pc4, e_imm;
    logic [4:0]  e_rd;
    bit          acc, algn, x_req, x_to, x_stall, x_mis;
    int          n, off;
    m_pend = 0; m_err = 0; e_rw = 0; e_ws = 0;
    e_alu = 0; e_rdat = 0; e_pc4 = 0; e_imm = 0; e_rd = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        m_pend = 0; m_err = 0; e_rw = 0; e_ws = 0;
        e_alu = 0; e_rdat = 0; e_pc4 = 0; e_imm = 0; e_rd = 0;
      end
      chk("wb.RegWrite", RegWrite_o, e_rw);
      chk("wb.WriteSrc", WriteSrc_o, e_ws);
      chk("wb.ALUout",   ALUout_o,   e_alu);
      chk("wb.ReadData", ReadData_o, e_rdat);
      chk("wb.pcPlus4",  pcPlus4_o,  e_pc4);
      chk("wb.ImmOp",    ImmOp_o,    e_imm);
      chk("wb.rd",       rd_o,       e_rd);
      chk("err",         err_o,      m_err);

      acc     = (WriteSrc_i == 2'b01) || MemWrite_i;
      n       = nbytes(funct3_i);
      off     = int'(ALUout_i[1:0]);
      algn    = (off % n) == 0;
      x_mis   = acc && !algn && (m_pend == 0);
      x_req   = rst_ni && ((m_pend > 0) || (acc && algn));
      x_to    = x_req && !dmem_ready_i && (m_pend == MEM_TIMEOUT - 1);
      x_stall = x_req && !dmem_ready_i && !x_to;

      chk("req",      dmem_req_o, x_req);
      chk("stall",    stall_o,    x_stall);
      chk("misalign", misalign_o, x_mis);
      chk("PCsrc",    PCsrc_o,    Jump_i | Ret_i | (Branch_i & (EQ_i != funct3_i[0])));
      chk("PCTarget", PCTarget_o, Ret_i ? (ALUout_i & ~32'h1) : pcPlusImm_i);
      chk("ALUResultM", ALUResultM_o, ALUout_i);
      chk("RegWriteM",  RegWriteM_o,  RegWrite_i);
      chk("rdM",        rdM_o,        rd_i);
      if (x_req) begin
        chk("we",   dmem_we_o,   MemWrite_i);
        chk("addr", dmem_addr_o, ALUout_i & ~32'h3);
        if (MemWrite_i) begin
          chk("be",    dmem_be_o,    m_be(funct3_i, ALUout_i));
          chk("wdata", dmem_wdata_o, m_wdata(funct3_i, regOp2_i));
        end
      end

      if (rst_ni) begin
        e_rw   = RegWrite_i && !x_stall && !x_mis && !x_to;
        e_ws   = x_stall ? 2'b00 : WriteSrc_i;
        e_alu  = ALUout_i;
        e_rdat = (x_req && dmem_ready_i) ? m_load(funct3_i, ALUout_i, dmem_rdata_i) : 32'h0;
        e_pc4  = pcPlus4_i;
        e_imm  = ImmOp_i;
        e_rd   = rd_i;
        if (x_mis || x_to) m_err = 1;
        m_pend = x_stall ? m_pend + 1 : 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic        l_req, l_we, l_mis, l_done, l_pcsrc;
  logic [3:0]  l_be;
  logic [31:0] l_addr, l_wdata, l_tgt;
  int          l_stalls;

  task automatic nop();
    WriteSrc_i = 2'b00; MemWrite_i = 0; RegWrite_i = 0; Branch_i = 0; Jump_i = 0; Ret_i = 0;
    dmem_ready_i = 0;
    @(posedge clk_i); #1;
  endtask

  // Present one instruction and hold it until the stage stops stalling.
  // delay: cycle index at which ready rises (-1 = never).
  task automatic issue(input logic [1:0] ws, input logic mw, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sdata, input logic rw,
                       input logic [4:0] rd, input int delay, input logic [31:0] rdata);
    WriteSrc_i = ws; MemWrite_i = mw; funct3_i = f3; ALUout_i = addr; regOp2_i = sdata;
    RegWrite_i = rw; rd_i = rd; Branch_i = 0; Jump_i = 0; Ret_i = 0; EQ_i = 0;
    pcPlus4_i = addr + 32'd4; ImmOp_i = addr ^ 32'h5A5A0000; pcPlusImm_i = 32'h1000;
    l_stalls = 0; l_done = 0;
    for (int k = 0; k < 40 && !l_done; k++) begin
      dmem_ready_i = (delay >= 0) && (k >= delay);
      dmem_rdata_i = dmem_ready_i ? rdata : 32'hA5A5A5A5;
      @(negedge clk_i);
      if (k == 0) begin
        l_req = dmem_req_o; l_we = dmem_we_o; l_be = dmem_be_o;
        l_addr = dmem_addr_o; l_wdata = dmem_wdata_o; l_mis = misalign_o;
      end
      if (stall_o) l_stalls++;
      else l_done = 1;
      @(posedge clk_i); #1;
    end
    chk("issue_bounded", l_done, 1'b1);
    dmem_ready_i = 0;
  endtask

  task automatic cf(input logic br, input logic j, input logic r, input logic eq,
                    input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pimm);
    WriteSrc_i = 2'b10; MemWrite_i = 0; RegWrite_i = j | r; funct3_i = f3; ALUout_i = alu;
    pcPlusImm_i = pimm; Branch_i = br; Jump_i = j; Ret_i = r; EQ_i = eq; dmem_ready_i = 0;
    @(negedge clk_i);
    l_pcsrc = PCsrc_o; l_tgt = PCTarget_o;
    @(posedge clk_i); #1;
    Branch_i = 0; Jump_i = 0; Ret_i = 0;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
    int          dly;
  } ld_vec_t;

  ld_vec_t lv[5] = '{
    '{3'b000, 32'h103, 32'h80FF1234, 32'hFFFFFF80, 3},
    '{3'b101, 32'h102, 32'hBEEF0000, 32'h0000BEEF, 1},
    '{3'b001, 32'h102, 32'h80017FFF, 32'hFFFF8001, 0},
    '{3'b100, 32'h101, 32'h0000AB00, 32'h000000AB, 2},
    '{3'b010, 32'h204, 32'h12345678, 32'h12345678, 0}
  };

  initial begin : stim
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst.req", dmem_req_o, 1'b0);
    chk("rst.err", err_o, 1'b0);
    rst_ni = 1;
    nop();

    // SW, zero-wait
    issue(2'b00, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1'b0, 5'd0, 0, 32'h0);
    chk("sw.req", l_req, 1'b1);
    chk("sw.we", l_we, 1'b1);
    chk("sw.be", l_be, 4'b1111);
    chk("sw.addr", l_addr, 32'h100);
    chk("sw.wdata", l_wdata, 32'hDEADBEEF);
    chk("sw.stalls", l_stalls, 0);

    // SH to upper half, immediately followed by loads
    issue(2'b00, 1'b1, 3'b001, 32'h102, 32'h00001234, 1'b0, 5'd0, 0, 32'h0);
    chk("sh.be", l_be, 4'b1100);
    chk("sh.wdata", l_wdata, 32'h12341234);

    foreach (lv[i]) begin
      issue(2'b01, 1'b0, lv[i].f3, lv[i].addr, 32'h0, 1'b1, 5'(i + 3), lv[i].dly, lv[i].rdata);
      chk($sformatf("ld%0d.stalls", i), l_stalls, lv[i].dly);
      chk($sformatf("ld%0d.RegWrite", i), RegWrite_o, 1'b1);
      chk($sformatf("ld%0d.ReadData", i), ReadData_o, lv[i].exp);
      chk($sformatf("ld%0d.rd", i), rd_o, 5'(i + 3));
    end

    // ALU write-back passes through
    issue(2'b00, 1'b0, 3'b000, 32'h0000_0777, 32'h0, 1'b1, 5'd9, 0, 32'h0);
    chk("alu.RegWrite", RegWrite_o, 1'b1);
    chk("alu.ALUout", ALUout_o, 32'h777);

    // Redirects
    cf(1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 32'h0, 32'h40);
    chk("bne.PCsrc", l_pcsrc, 1'b1);
    chk("bne.target", l_tgt, 32'h40);
    cf(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h40);
    chk("beq_nt.PCsrc", l_pcsrc, 1'b0);
    cf(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h81, 32'h40);
    chk("ret.PCsrc", l_pcsrc, 1'b1);
    chk("ret.target", l_tgt, 32'h80);

    // Misaligned word load
    issue(2'b01, 1'b0, 3'b010, 32'h101, 32'h0, 1'b1, 5'd7, 0, 32'h11111111);
    chk("mis.req", l_req, 1'b0);
    chk("mis.pulse", l_mis, 1'b1);
    chk("mis.RegWrite", RegWrite_o, 1'b0);
    chk("mis.err", err_o, 1'b1);
    issue(2'b00, 1'b1, 3'b001, 32'h103, 32'hFFFF, 1'b0, 5'd0, 0, 32'h0);
    nop();

    // Reset clears the sticky error
    rst_ni = 0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1;
    chk("rst2.err", err_o, 1'b0);

    // Load that never completes
    issue(2'b01, 1'b0, 3'b010, 32'h200, 32'h0, 1'b1, 5'd12, -1, 32'h0);
    chk("to.stalls", l_stalls, MEM_TIMEOUT - 1);
    chk("to.err", err_o, 1'b1);
    chk("to.RegWrite", RegWrite_o, 1'b0);
    chk("to.ReadData", ReadData_o, 32'h0);
    nop();
    chk("to.stall_after", stall_o, 1'b0);

    // Reset asserted mid-WAIT
    WriteSrc_i = 2'b01; MemWrite_i = 0; funct3_i = 3'b010; ALUout_i = 32'h300;
    RegWrite_i = 1; rd_i = 5'd21; dmem_ready_i = 0;
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 0;
    #1;
    chk("midrst.req", dmem_req_o, 1'b0);
    chk("midrst.stall", stall_o, 1'b0);
    chk("midrst.rd_o", rd_o, 5'd0);
    chk("midrst.ALUout_o", ALUout_o, 32'h0);
    chk("midrst.err", err_o, 1'b0);
    nop();
    nop();
    rst_ni = 1;

    // Stage recovers after reset
    issue(2'b01, 1'b0, 3'b000, 32'h103, 32'h0, 1'b1, 5'd2, 1, 32'h7F000000);
    chk("post.ReadData", ReadData_o, 32'h0000007F);
    nop();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
